// File: rtl/adc_emulator.sv
// Serial-ADC responder for the 3-wire ADS7883-style frame. It shifts a selected
// sample source out MSB first on adc_sd, one frame per falling edge of adc_cs.
module adc_emulator #(
  parameter int unsigned      WIDTH     = 12,
  parameter logic [WIDTH-1:0] RAMP_STEP = 12'h001,
  parameter logic [WIDTH-1:0] LFSR_SEED = 12'h001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adc_cs,
  output logic             adc_sd,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             sample_req,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun,
  input  logic             underrun_clr
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WIDTH - 1);

  state_t           state_r;
  logic [3:0]       cnt_r;
  logic [WIDTH-1:0] shreg_r;
  logic             cs_q_r;
  logic             adc_sd_r;
  logic             busy_r;
  logic             sample_req_r;
  logic             frame_done_r;
  logic             underrun_r;
  logic [WIDTH-1:0] hold_r;
  logic             fresh_r;
  logic [WIDTH-1:0] ramp_r;
  logic [WIDTH-1:0] lfsr_r;
  logic             sq_r;

  logic             start_s;
  logic             start_go_s;
  logic             m0_start_s;
  logic [WIDTH-1:0] src_s;

  // Taps for x^12 + x^11 + x^10 + x^4 + 1, shifting left.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
    lfsr_next = {v[WIDTH-2:0], v[WIDTH-1] ^ v[WIDTH-2] ^ v[WIDTH-3] ^ v[3]};
  endfunction

  assign start_s    = cs_q_r & ~adc_cs;
  assign start_go_s = start_s & (state_r == ST_IDLE);
  assign m0_start_s = start_go_s & (mode == 2'd0);

  assign adc_sd     = adc_sd_r;
  assign busy       = busy_r;
  assign sample_req = sample_req_r;
  assign frame_done = frame_done_r;
  assign underrun   = underrun_r;

  // Source value as it stands before the current edge.
  always_comb begin
    src_s = hold_r;
    case (mode)
      2'd0:    src_s = hold_r;
      2'd1:    src_s = ramp_r;
      2'd2:    src_s = lfsr_r;
      2'd3:    src_s = {WIDTH{sq_r}};
      default: src_s = hold_r;
    endcase
  end

  // Frame sequencer: start detect, shift-out, abort and completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      shreg_r      <= '0;
      cs_q_r       <= 1'b1;
      adc_sd_r     <= 1'b0;
      busy_r       <= 1'b0;
      sample_req_r <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      cs_q_r       <= adc_cs;
      sample_req_r <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            shreg_r      <= {src_s[WIDTH-2:0], 1'b0};
            adc_sd_r     <= src_s[WIDTH-1];
            busy_r       <= 1'b1;
            cnt_r        <= CNT_INIT;
            sample_req_r <= (mode == 2'd0);
            state_r      <= ST_SHIFT;
          end else begin
            adc_sd_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // A chip-select seen high mid-frame cancels it without frame_done.
          if (adc_cs) begin
            adc_sd_r <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end else if (cnt_r == 4'd0) begin
            adc_sd_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            adc_sd_r <= shreg_r[WIDTH-1];
            shreg_r  <= {shreg_r[WIDTH-2:0], 1'b0};
            cnt_r    <= cnt_r - 4'd1;
          end
        end
        default: begin
          adc_sd_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // Mode-0 hold register, freshness flag and sticky underrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_r     <= '0;
      fresh_r    <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (in_valid) begin
        hold_r <= in_data;
      end else begin
        hold_r <= hold_r;
      end
      // A write on the start edge keeps the new sample marked fresh.
      if (in_valid) begin
        fresh_r <= 1'b1;
      end else if (m0_start_s) begin
        fresh_r <= 1'b0;
      end else begin
        fresh_r <= fresh_r;
      end
      if (m0_start_s && !fresh_r) begin
        underrun_r <= 1'b1;
      end else if (underrun_clr) begin
        underrun_r <= 1'b0;
      end else begin
        underrun_r <= underrun_r;
      end
    end
  end

  // Generated sources advance only on a start edge and only when selected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ramp_r <= '0;
      lfsr_r <= LFSR_SEED;
      sq_r   <= 1'b0;
    end else if (start_go_s) begin
      case (mode)
        2'd1:    ramp_r <= ramp_r + RAMP_STEP;
        2'd2:    lfsr_r <= lfsr_next(lfsr_r);
        2'd3:    sq_r   <= ~sq_r;
        default: ramp_r <= ramp_r;
      endcase
    end else begin
      ramp_r <= ramp_r;
    end
  end

endmodule

// File: tb/tb_adc_emulator.sv
// Directed bench for adc_emulator: two instances (default ramp step and 0x800)
// share all inputs; frames are captured bit by bit and compared to fixed words.
module tb_adc_emulator;

  logic        clk;
  logic        reset;
  logic        adc_cs;
  logic [1:0]  mode;
  logic [11:0] in_data;
  logic        in_valid;
  logic        underrun_clr;

  logic adc_sd, sample_req, busy, frame_done, underrun;
  logic adc_sd2, sample_req2, busy2, frame_done2, underrun2;

  int total = 0;
  int bad   = 0;

  logic [11:0] w1, w2;
  logic        req, uf, done;

  adc_emulator dut (
    .clk(clk), .reset(reset), .adc_cs(adc_cs), .adc_sd(adc_sd), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .sample_req(sample_req), .busy(busy),
    .frame_done(frame_done), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  adc_emulator #(.RAMP_STEP(12'h800)) dut2 (
    .clk(clk), .reset(reset), .adc_cs(adc_cs), .adc_sd(adc_sd2), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .sample_req(sample_req2), .busy(busy2),
    .frame_done(frame_done2), .underrun(underrun2), .underrun_clr(underrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the start edge: collects 12 bits, then the done edge.
  task automatic capture(output logic [11:0] a, output logic [11:0] b, output logic d);
    for (int i = 0; i < 12; i++) begin
      a[11-i] = adc_sd;
      b[11-i] = adc_sd2;
      if (i < 11) tick();
    end
    tick();
    d = frame_done;
  endtask

  task automatic run_frame(input logic v, input logic [11:0] dat, input logic clr,
                           output logic [11:0] a, output logic [11:0] b,
                           output logic r, output logic u, output logic d);
    adc_cs = 1'b1;
    tick();
    adc_cs       = 1'b0;
    in_valid     = v;
    in_data      = dat;
    underrun_clr = clr;
    tick();
    in_valid     = 1'b0;
    underrun_clr = 1'b0;
    r = sample_req;
    u = underrun;
    capture(a, b, d);
  endtask

  initial begin
    reset        = 1'b0;
    adc_cs       = 1'b1;
    mode         = 2'd0;
    in_data      = 12'h000;
    in_valid     = 1'b0;
    underrun_clr = 1'b0;
    #3;
    check("rst_sd", adc_sd, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req", sample_req, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_uf", underrun, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("idle_busy", busy, 1'b0);

    // Mode 0: fresh sample 0xA5C
    in_valid = 1'b1;
    in_data  = 12'hA5C;
    tick();
    in_valid = 1'b0;
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("m0_word", w1, 12'hA5C);
    check("m0_req", req, 1'b1);
    check("m0_uf", uf, 1'b0);
    check("m0_done", done, 1'b1);
    check("m0_end_busy", busy, 1'b0);
    check("m0_end_sd", adc_sd, 1'b0);
    tick();
    check("m0_done_once", frame_done, 1'b0);
    tick();
    tick();
    check("cs_low_no_frame", busy, 1'b0);

    // Underrun: one sample, two frames
    in_valid = 1'b1;
    in_data  = 12'h123;
    tick();
    in_valid = 1'b0;
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("ur_word1", w1, 12'h123);
    check("ur_uf1", underrun, 1'b0);
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("ur_word2", w1, 12'h123);
    check("ur_uf2", underrun, 1'b1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("ur_clr", underrun, 1'b0);

    // Clear coinciding with an underrun event: set wins
    run_frame(1'b0, 12'h000, 1'b1, w1, w2, req, uf, done);
    check("ur_set_wins", uf, 1'b1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("ur_clr2", underrun, 1'b0);

    // in_valid on the start edge: old value sent, new one stays fresh
    in_valid = 1'b1;
    in_data  = 12'h321;
    tick();
    in_valid = 1'b0;
    run_frame(1'b1, 12'h456, 1'b0, w1, w2, req, uf, done);
    check("same_edge_old", w1, 12'h321);
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("same_edge_new", w1, 12'h456);
    check("same_edge_uf", underrun, 1'b0);
    check("same_edge_req", req, 1'b1);

    // Mode 2: LFSR
    mode = 2'd2;
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("lfsr1", w1, 12'h001);
    check("lfsr_req", req, 1'b0);
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("lfsr2", w1, 12'h002);

    // Mode 3: square
    mode = 2'd3;
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("sq1", w1, 12'h000);
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("sq2", w1, 12'hFFF);
    check("sq2_done", done, 1'b1);
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("sq3", w1, 12'h000);

    // Abort during a 0xFFF frame, 5 edges in
    adc_cs = 1'b1;
    tick();
    adc_cs = 1'b0;
    tick();
    check("ab_msb", adc_sd, 1'b1);
    check("ab_busy", busy, 1'b1);
    tick();
    tick();
    tick();
    tick();
    check("ab_mid_sd", adc_sd, 1'b1);
    adc_cs = 1'b1;
    tick();
    check("ab_sd", adc_sd, 1'b0);
    check("ab_busy0", busy, 1'b0);
    check("ab_nodone", frame_done, 1'b0);
    adc_cs = 1'b0;
    tick();
    check("ab_restart_nodone", frame_done, 1'b0);
    check("ab_restart_busy", busy, 1'b1);
    capture(w1, w2, done);
    check("ab_next_word", w1, 12'h000);
    check("ab_next_done", done, 1'b1);

    // Asynchronous reset mid-frame (0xFFF frame)
    adc_cs = 1'b1;
    tick();
    adc_cs = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("pre_rst_sd", adc_sd, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_sd", adc_sd, 1'b0);
    check("arst_busy", busy, 1'b0);
    adc_cs = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    mode  = 2'd1;

    // Mode 1 ramp from reset: step 1 and step 0x800
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("ramp1_a", w1, 12'h000);
    check("ramp1_b", w2, 12'h000);
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("ramp2_a", w1, 12'h001);
    check("ramp2_b", w2, 12'h800);
    run_frame(1'b0, 12'h000, 1'b0, w1, w2, req, uf, done);
    check("ramp3_a", w1, 12'h002);
    check("ramp3_b", w2, 12'h000);
    check("ramp3_done", frame_done2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
